bus_rr_arbiter: RTL and testbench
=================================

// Module: bus_rr_arbiter
// PURPOSE
//  Round-robin arbiter for the shared single-wire serial bus (b_BUS/b_RW/b_bus_utilizing).
//  Takes per-master requests and issues a one-hot grant to one master at a time.
//  Holds the grant while the winner drives b_bus_utilizing low, and revokes grants
//  that are never used (timeout). Reports current master id and cumulative bus-busy cycles.
// PARAMETERS
//  NUM_MASTERS  12  number of request/grant lines
//  MID_WIDTH    4   width of master id; 2**MID_WIDTH >= NUM_MASTERS
//  TIMEOUT_LEN  6   grant timeout counter width in bits; timeout = 2**TIMEOUT_LEN cycles
//  UTIL_WIDTH   16  width of the bus-busy cycle counter
// PORTS
//  clk          in   1            single clock; all state on rising edge
//  rst          in   1            synchronous, active-high reset
//  m_reqs       in   NUM_MASTERS  level request per master; held until its transaction ends
//  bus_util     in   1            b_bus_utilizing; active-low, pulled up; 0 = transaction in progress
//  m_grants     out  NUM_MASTERS  one-hot or zero grant, registered
//  grant_valid  out  1            1 when any m_grants bit is set
//  mid_current  out  MID_WIDTH    id of granted master; holds last winner when idle
//  timeout_evt  out  1            one-cycle pulse when an unused grant is revoked
//  util_cnt     out  UTIL_WIDTH   saturating count of cycles with bus_util==0
//  state        out  2            FSM state, for SSD debug display
// BEHAVIOUR
//  Reset (rst=1 at edge): m_grants=0, grant_valid=0, mid_current=0, timeout_evt=0,
//   util_cnt=0, state=IDLE, rr pointer last=NUM_MASTERS-1 (master 0 has top priority first).
//   Reset mid-transaction drops the grant on that same edge; no RELEASE cycle.
//  FSM states: IDLE=0, GRANT=1, BUSY=2, RELEASE=3.
//  IDLE: if |m_reqs, winner = first set index strictly after last, searching upward and
//   wrapping past NUM_MASTERS-1 to 0. Next edge: m_grants[winner]=1, mid_current=winner,
//   last=winner, tmo_cnt=0, go to GRANT. Latency request->grant is 1 cycle.
//  GRANT: if bus_util==0 -> BUSY. Else if m_reqs[winner]==0 -> RELEASE (no timeout_evt).
//   Else if tmo_cnt == 2**TIMEOUT_LEN-1 -> RELEASE with timeout_evt=1 for 1 cycle.
//   Else tmo_cnt++. bus_util==0 takes priority over a simultaneous request drop or timeout.
//  BUSY: grant held; no timeout. When bus_util returns to 1 -> RELEASE. A dropped request
//   while bus_util==0 does not end BUSY.
//  RELEASE: m_grants=0 for exactly 1 cycle (bus turnaround), then IDLE. Requests are
//   sampled again only in IDLE, so back-to-back grants are separated by at least 2 cycles.
//  Requests arriving in GRANT/BUSY/RELEASE are never lost: they are level-held and seen in IDLE.
//  Requests on a nonexistent master index are impossible by width. Winner uses only NUM_MASTERS bits.
//  util_cnt: +1 on each cycle with bus_util==0 in any state; saturates at all-ones, no wrap.
//  grant_valid == |m_grants at all times. m_grants is never multi-hot.
// STRUCTURE
//  Shared header bus_defs: FSM state encodings, NUM_MASTERS, MID_WIDTH defaults.
//   Also used by bus controller debug and SSD muxing.
//  Sub-module rr_pick (combinational): inputs reqs, last; outputs any, winner id.
//   Implemented as a rotate / priority-encode / un-rotate.
//  Top: FSM, tmo_cnt, util_cnt, output registers.
// TESTING
//  1 rst, then m_reqs=12'h014 -> m_grants=12'h004 one cycle after IDLE, mid_current=2, state=GRANT.
//  2 Continue test 1: master2 pulls bus_util low 10 cycles, then high, keeps request.
//    -> BUSY 10 cycles; RELEASE with grants 0 for 1 cycle; next grant 12'h010 (mid 4);
//    -> after that, back to master 2; util_cnt=10.
//  3 Grant master2, bus_util held 1 -> m_grants drops after 64 cycles in GRANT;
//    -> timeout_evt=1 for exactly 1 cycle; next winner master 4 if requesting.
//  4 Grant master4; master4 drops m_reqs[4] at GRANT cycle 5
//    -> RELEASE next edge, timeout_evt stays 0, then IDLE.
//  5 rst asserted during BUSY of master4 -> m_grants=0 on that edge.
//    After rst deasserts with m_reqs=12'h011: grant goes to master 0.
//  6 Wrap: last=11, m_reqs=12'h801 -> master 0 granted.
//    Force util_cnt near max, hold bus_util=0 -> util_cnt saturates at 16'hFFFF.

Source files
------------

// File: rtl/bus_rr_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// bus_rr_arbiter_pkg
//  Shared definitions for the serial-bus arbiter and anything that decodes its
//  debug outputs (bus controller debug, SSD muxing).
//  Contents:
//   - default geometry of the arbiter (master count, id width, timeout, counter)
//   - FSM state encoding, exported on the arbiter's 'state' port
// -----------------------------------------------------------------------------
package bus_rr_arbiter_pkg;

  // Default geometry. 2**MID_WIDTH_DEF must cover NUM_MASTERS_DEF.
  localparam int NUM_MASTERS_DEF = 12;
  localparam int MID_WIDTH_DEF   = 4;
  localparam int TIMEOUT_LEN_DEF = 6;
  localparam int UTIL_WIDTH_DEF  = 16;

  // Encodings are fixed because the debug display decodes the raw 2-bit value.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GRANT   = 2'd1,
    ST_BUSY    = 2'd2,
    ST_RELEASE = 2'd3
  } bus_state_e;

endpackage

// File: rtl/bus_rr_arbiter_rr_pick.sv
// -----------------------------------------------------------------------------
// bus_rr_arbiter_rr_pick
//  Combinational round-robin winner selection.
//  The request vector is rotated so the master just after i_last lands at
//  position 0, the lowest set bit is priority-encoded, and the position is
//  rotated back into a real master id. i_last itself is searched last, so a
//  lone requester that just won is still picked again.
//  Ports:
//   i_reqs    in   NUM_MASTERS  level requests
//   i_last    in   MID_WIDTH    id of the previous winner
//   o_any     out  1            at least one request present
//   o_winner  out  MID_WIDTH    selected master id (valid when o_any)
// -----------------------------------------------------------------------------
module bus_rr_arbiter_rr_pick
  import bus_rr_arbiter_pkg::*;
#(
  parameter int NUM_MASTERS = NUM_MASTERS_DEF,
  parameter int MID_WIDTH   = MID_WIDTH_DEF
) (
  input  logic [NUM_MASTERS-1:0] i_reqs,
  input  logic [MID_WIDTH-1:0]   i_last,
  output logic                   o_any,
  output logic [MID_WIDTH-1:0]   o_winner
);

  // One extra bit so (start + offset) can be compared against NUM_MASTERS
  // before folding back into range.
  localparam logic [MID_WIDTH:0]   N_EXT    = (MID_WIDTH+1)'(NUM_MASTERS);
  localparam logic [MID_WIDTH-1:0] LAST_IDX = MID_WIDTH'(NUM_MASTERS - 1);

  logic [MID_WIDTH-1:0]   w_start;
  logic [NUM_MASTERS-1:0] w_rot;
  logic [MID_WIDTH-1:0]   w_pos;
  logic [MID_WIDTH:0]     w_sum;

  // Search starts one past the previous winner; wraps from the top master to 0.
  assign w_start = (i_last >= LAST_IDX) ? '0 : (i_last + MID_WIDTH'(1));

  // Rotate: w_rot[k] is the request of master (w_start + k) mod NUM_MASTERS.
  generate
    for (genvar gi = 0; gi < NUM_MASTERS; gi++) begin : g_rot
      logic [MID_WIDTH:0]   w_idx_ext;
      logic [MID_WIDTH-1:0] w_idx;
      assign w_idx_ext  = {1'b0, w_start} + (MID_WIDTH+1)'(gi);
      assign w_idx      = (w_idx_ext >= N_EXT) ? MID_WIDTH'(w_idx_ext - N_EXT)
                                               : w_idx_ext[MID_WIDTH-1:0];
      assign w_rot[gi]  = i_reqs[w_idx];
    end
  endgenerate

  // Priority-encode the lowest set position of the rotated vector.
  always_comb begin
    w_pos = '0;
    for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
      if (w_rot[i]) begin
        w_pos = MID_WIDTH'(i);
      end
    end
  end

  // Un-rotate back to an absolute master id.
  assign w_sum    = {1'b0, w_start} + {1'b0, w_pos};
  assign o_winner = (w_sum >= N_EXT) ? MID_WIDTH'(w_sum - N_EXT) : w_sum[MID_WIDTH-1:0];
  assign o_any    = |i_reqs;

endmodule

// File: rtl/bus_rr_arbiter.sv
// -----------------------------------------------------------------------------
// bus_rr_arbiter
//  Round-robin arbiter for the shared single-wire serial bus. One master at a
//  time receives a one-hot grant. The grant is held while the winner keeps
//  bus_util low, dropped when the winner withdraws its request, and revoked
//  if it is never used within 2**TIMEOUT_LEN cycles. Every grant is followed
//  by a one-cycle RELEASE turnaround with no grant asserted.
//  Ports:
//   clk          in   1            clock, all state on rising edge
//   rst          in   1            synchronous active-high reset
//   m_reqs       in   NUM_MASTERS  level request per master
//   bus_util     in   1            active-low bus-in-use line (0 = busy)
//   m_grants     out  NUM_MASTERS  registered one-hot (or zero) grant
//   grant_valid  out  1            registered, equals |m_grants
//   mid_current  out  MID_WIDTH    id of current / most recent winner
//   timeout_evt  out  1            one-cycle pulse when an unused grant is revoked
//   util_cnt     out  UTIL_WIDTH   saturating count of cycles with bus_util==0
//   state        out  2            FSM state for debug display
// -----------------------------------------------------------------------------
module bus_rr_arbiter
  import bus_rr_arbiter_pkg::*;
#(
  parameter int NUM_MASTERS = NUM_MASTERS_DEF,
  parameter int MID_WIDTH   = MID_WIDTH_DEF,
  parameter int TIMEOUT_LEN = TIMEOUT_LEN_DEF,
  parameter int UTIL_WIDTH  = UTIL_WIDTH_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_MASTERS-1:0] m_reqs,
  input  logic                   bus_util,
  output logic [NUM_MASTERS-1:0] m_grants,
  output logic                   grant_valid,
  output logic [MID_WIDTH-1:0]   mid_current,
  output logic                   timeout_evt,
  output logic [UTIL_WIDTH-1:0]  util_cnt,
  output logic [1:0]             state
);

  localparam logic [TIMEOUT_LEN-1:0] TMO_MAX  = '1;
  localparam logic [UTIL_WIDTH-1:0]  UTIL_MAX = '1;
  localparam logic [MID_WIDTH-1:0]   LAST_RST = MID_WIDTH'(NUM_MASTERS - 1);

  bus_state_e             r_state;
  logic [NUM_MASTERS-1:0] r_grants;
  logic                   r_grant_valid;
  logic [MID_WIDTH-1:0]   r_mid;
  logic [MID_WIDTH-1:0]   r_last;
  logic [TIMEOUT_LEN-1:0] r_tmo;
  logic                   r_timeout_evt;
  logic [UTIL_WIDTH-1:0]  r_util;

  logic                   w_any;
  logic [MID_WIDTH-1:0]   w_winner;
  logic [NUM_MASTERS-1:0] w_onehot;
  logic                   w_owner_req;

  bus_rr_arbiter_rr_pick #(
    .NUM_MASTERS (NUM_MASTERS),
    .MID_WIDTH   (MID_WIDTH)
  ) u_pick (
    .i_reqs   (m_reqs),
    .i_last   (r_last),
    .o_any    (w_any),
    .o_winner (w_winner)
  );

  // Decode the winner id into the grant vector; exactly one bit by construction.
  generate
    for (genvar gi = 0; gi < NUM_MASTERS; gi++) begin : g_onehot
      assign w_onehot[gi] = (w_winner == MID_WIDTH'(gi));
    end
  endgenerate

  // r_mid always names the master currently holding the grant while in GRANT/BUSY.
  assign w_owner_req = m_reqs[r_mid];

  always_ff @(posedge clk) begin
    if (rst) begin
      // Drops any live grant immediately, even mid-transaction.
      r_state       <= ST_IDLE;
      r_grants      <= '0;
      r_grant_valid <= 1'b0;
      r_mid         <= '0;
      r_last        <= LAST_RST;
      r_tmo         <= '0;
      r_timeout_evt <= 1'b0;
      r_util        <= '0;
    end else begin
      r_timeout_evt <= 1'b0;

      // Bus occupancy is counted independently of arbitration state.
      if (!bus_util && (r_util != UTIL_MAX)) begin
        r_util <= r_util + UTIL_WIDTH'(1);
      end

      case (r_state)
        ST_IDLE: begin
          if (w_any) begin
            r_grants      <= w_onehot;
            r_grant_valid <= 1'b1;
            r_mid         <= w_winner;
            r_last        <= w_winner;
            r_tmo         <= '0;
            r_state       <= ST_GRANT;
          end
        end

        ST_GRANT: begin
          // Bus use wins over a simultaneous request drop or timeout.
          if (!bus_util) begin
            r_state <= ST_BUSY;
          end else if (!w_owner_req) begin
            r_grants      <= '0;
            r_grant_valid <= 1'b0;
            r_state       <= ST_RELEASE;
          end else if (r_tmo == TMO_MAX) begin
            r_grants      <= '0;
            r_grant_valid <= 1'b0;
            r_timeout_evt <= 1'b1;
            r_state       <= ST_RELEASE;
          end else begin
            r_tmo <= r_tmo + TIMEOUT_LEN'(1);
          end
        end

        ST_BUSY: begin
          // Only the end of bus activity closes the transaction.
          if (bus_util) begin
            r_grants      <= '0;
            r_grant_valid <= 1'b0;
            r_state       <= ST_RELEASE;
          end
        end

        ST_RELEASE: begin
          // One idle turnaround cycle; requests are re-sampled in IDLE.
          r_state <= ST_IDLE;
        end

        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign m_grants    = r_grants;
  assign grant_valid = r_grant_valid;
  assign mid_current = r_mid;
  assign timeout_evt = r_timeout_evt;
  assign util_cnt    = r_util;
  assign state       = r_state;

endmodule

// File: tb/tb_bus_rr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_bus_rr_arbiter
//  Directed scenarios for the round-robin bus arbiter. A reference model,
//  tracking grant ownership as a plain master number, is compared against the
//  DUT after every clock edge; hand-computed values pin key points of each
//  scenario.
// -----------------------------------------------------------------------------
module tb_bus_rr_arbiter;

  localparam int N  = 12;
  localparam int MW = 4;
  localparam int TL = 6;
  localparam int UW = 16;
  localparam int UTIL_MAX = (1 << UW) - 1;

  logic          clk;
  logic          rst;
  logic [N-1:0]  m_reqs;
  logic          bus_util;
  logic [N-1:0]  m_grants;
  logic          grant_valid;
  logic [MW-1:0] mid_current;
  logic          timeout_evt;
  logic [UW-1:0] util_cnt;
  logic [1:0]    state;

  int n_checks = 0;
  int n_errors = 0;

  bus_rr_arbiter #(
    .NUM_MASTERS (N),
    .MID_WIDTH   (MW),
    .TIMEOUT_LEN (TL),
    .UTIL_WIDTH  (UW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .m_reqs      (m_reqs),
    .bus_util    (bus_util),
    .m_grants    (m_grants),
    .grant_valid (grant_valid),
    .mid_current (mid_current),
    .timeout_evt (timeout_evt),
    .util_cnt    (util_cnt),
    .state       (state)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      if (n_errors <= 40)
        $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Directed step: one line per checked transaction point.
  task automatic lit(input string name, input logic [31:0] got, input logic [31:0] exp);
    $display("step %-14s got=%0h exp=%0h", name, got, exp);
    check(name, got, exp);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // ---------------------------------------------------------------------------
  // Reference model. Phase: 0 idle, 1 granted/unused, 2 bus in use, 3 turnaround.
  // md_owner is the granted master or -1; md_age counts cycles spent granted
  // without bus use, including the current one.
  // ---------------------------------------------------------------------------
  int md_phase, md_owner, md_mid, md_last, md_age, md_util;
  bit md_tevt;

  always @(posedge clk) begin
    if (rst) begin
      md_phase = 0; md_owner = -1; md_mid = 0; md_last = N - 1;
      md_age = 0; md_tevt = 0; md_util = 0;
    end else begin
      md_tevt = 0;
      if (bus_util == 1'b0 && md_util < UTIL_MAX) md_util = md_util + 1;
      case (md_phase)
        0: if (m_reqs != '0) begin
             bit found;
             found = 0;
             for (int k = 1; k <= N; k++) begin
               int c;
               c = (md_last + k) % N;
               if (!found && m_reqs[c]) begin
                 md_owner = c;
                 found = 1;
               end
             end
             md_last = md_owner; md_mid = md_owner; md_age = 1; md_phase = 1;
           end
        1: if (bus_util == 1'b0) md_phase = 2;
           else if (!m_reqs[md_owner]) begin md_owner = -1; md_phase = 3; end
           else if (md_age == (1 << TL)) begin md_owner = -1; md_phase = 3; md_tevt = 1; end
           else md_age = md_age + 1;
        2: if (bus_util == 1'b1) begin md_owner = -1; md_phase = 3; end
        default: md_phase = 0;
      endcase
    end
  end

  // Compare process: DUT against model shortly after every rising edge.
  always @(posedge clk) begin
    logic [N-1:0] eg;
    #1;
    eg = '0;
    if (md_owner >= 0) eg[md_owner] = 1'b1;
    check("m_grants",    m_grants,    eg);
    check("grant_valid", grant_valid, (md_owner >= 0) ? 1 : 0);
    check("mid_current", mid_current, md_mid);
    check("timeout_evt", timeout_evt, md_tevt);
    check("util_cnt",    util_cnt,    md_util);
    check("state",       state,       md_phase);
  end

  initial begin
    rst = 1'b1; m_reqs = '0; bus_util = 1'b1;
    cyc(3);
    lit("rst_grants", m_grants, 0);
    lit("rst_gvalid", grant_valid, 0);
    lit("rst_state",  state, 0);
    lit("rst_mid",    mid_current, 0);
    lit("rst_util",   util_cnt, 0);
    lit("rst_tevt",   timeout_evt, 0);

    // 1: masters 2 and 4 request, master 2 wins first
    rst = 1'b0; m_reqs = 12'h014;
    cyc(1);
    lit("t1_grants", m_grants, 12'h004);
    lit("t1_mid",    mid_current, 2);
    lit("t1_state",  state, 1);
    lit("t1_gvalid", grant_valid, 1);

    // 2: master 2 uses the bus for 10 cycles
    bus_util = 1'b0;
    cyc(1);
    lit("t2_busy", state, 2);
    lit("t2_hold", m_grants, 12'h004);
    cyc(9);
    lit("t2_util10", util_cnt, 10);
    lit("t2_still_busy", state, 2);
    bus_util = 1'b1;
    cyc(1);
    lit("t2_release", state, 3);
    lit("t2_rel_gnt", m_grants, 0);
    cyc(1);
    lit("t2_idle", state, 0);
    cyc(1);
    lit("t2_next_gnt", m_grants, 12'h010);
    lit("t2_next_mid", mid_current, 4);
    // master 4 withdraws immediately, arbitration returns to master 2
    m_reqs = 12'h004;
    cyc(1);
    lit("t2_drop_rel", state, 3);
    lit("t2_drop_tevt", timeout_evt, 0);
    cyc(2);
    lit("t2_back2", m_grants, 12'h004);
    m_reqs = 12'h014;

    // 3: master 2 never uses the bus -> revoked after 64 granted cycles
    cyc(63);
    lit("t3_c64_gnt",  m_grants, 12'h004);
    lit("t3_c64_tevt", timeout_evt, 0);
    cyc(1);
    lit("t3_revoked", m_grants, 0);
    lit("t3_tevt",    timeout_evt, 1);
    lit("t3_state",   state, 3);
    cyc(1);
    lit("t3_tevt_off", timeout_evt, 0);
    cyc(1);
    lit("t3_next_gnt", m_grants, 12'h010);
    lit("t3_next_mid", mid_current, 4);

    // 4: master 4 drops its request in its 5th granted cycle
    cyc(4);
    m_reqs = 12'h000;
    cyc(1);
    lit("t4_release", state, 3);
    lit("t4_no_tevt", timeout_evt, 0);
    lit("t4_gnt0",    m_grants, 0);
    cyc(1);
    lit("t4_idle", state, 0);

    // 5: reset during master 4's transaction
    m_reqs = 12'h010;
    cyc(1);
    lit("t5_gnt4", m_grants, 12'h010);
    bus_util = 1'b0;
    cyc(3);
    lit("t5_busy", state, 2);
    lit("t5_util", util_cnt, 13);
    rst = 1'b1;
    cyc(1);
    lit("t5_rst_gnt",   m_grants, 0);
    lit("t5_rst_state", state, 0);
    lit("t5_rst_util",  util_cnt, 0);
    rst = 1'b0; bus_util = 1'b1; m_reqs = 12'h011;
    cyc(1);
    lit("t5_gnt0", m_grants, 12'h001);
    lit("t5_mid0", mid_current, 0);

    // 6: wrap from master 11 to master 0
    m_reqs = 12'h000;
    cyc(2);
    m_reqs = 12'h800;
    cyc(1);
    lit("t6_gnt11", m_grants, 12'h800);
    lit("t6_mid11", mid_current, 11);
    m_reqs = 12'h001;
    cyc(2);
    m_reqs = 12'h801;
    cyc(1);
    lit("t6_wrap_gnt", m_grants, 12'h001);
    lit("t6_wrap_mid", mid_current, 0);

    // util_cnt saturation with the bus held busy while idle
    m_reqs = 12'h000;
    cyc(2);
    lit("t6_idle", state, 0);
    bus_util = 1'b0;
    cyc(65534);
    lit("t6_util_fffe", util_cnt, 16'hFFFE);
    cyc(1);
    lit("t6_util_ffff", util_cnt, 16'hFFFF);
    cyc(3);
    lit("t6_util_sat", util_cnt, 16'hFFFF);
    lit("t6_sat_gnt",  m_grants, 0);
    bus_util = 1'b1;
    cyc(2);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
